// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, receiver state encoding and parity helper.
// Intended to be reused by a future host transmitter.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    // Parity bit that makes the total number of ones across data+parity odd.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Purpose: synchronise one raw PS/2 pin and debounce it with a stability counter.
// Latency: level and fall strobe update 2 + FILTER_LEN clk after a pin change.
// Backpressure: none; fall is a single-cycle strobe.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The counter tracks how long sync2 has disagreed with the filtered level;
    // the level flips on the FILTER_LEN-th consecutive disagreeing sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            fall  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                cnt   <= '0;
                fall  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_rx.sv
// Purpose: PS/2 host receiver; filters pins, assembles 11-bit frames, reports bytes/errors.
// Latency: result pulse one clk after the stop-bit falling edge (3 + FILTER_LEN after the pin).
// Backpressure: none; rx_valid is a one-cycle write strobe the consumer must take.
module ps2_host_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    input  logic       inhibit,
    output logic       ps2_clk_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int BW = $clog2(DATA_BITS);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic clk_lvl_unused;
    logic clk_fe;
    logic dat_lvl;
    logic dat_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_clk_in),
        .level (clk_lvl_unused),
        .fall  (clk_fe)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_dat_in),
        .level (dat_lvl),
        .fall  (dat_fall_unused)
    );

    ps2_state_t             state;
    ps2_state_t             state_nxt;
    logic [DATA_BITS-1:0]   shreg;
    logic [BW-1:0]          bit_cnt;
    logic                   par_bit;
    logic [TW-1:0]          tmo_cnt;

    logic start;
    logic shift;
    logic cap_par;
    logic eval;
    logic tmo_fire;
    logic tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Inhibit outranks everything; a falling edge outranks an expiring timeout.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift     = 1'b0;
        cap_par   = 1'b0;
        eval      = 1'b0;
        tmo_fire  = 1'b0;
        if (inhibit) begin
            state_nxt = IDLE;
        end else if (state != IDLE && !clk_fe && tmo_hit) begin
            state_nxt = IDLE;
            tmo_fire  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clk_fe && !dat_lvl) begin
                        state_nxt = DATA;
                        start     = 1'b1;
                    end
                end
                DATA: begin
                    if (clk_fe) begin
                        shift = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (clk_fe) begin
                        cap_par   = 1'b1;
                        state_nxt = STOP;
                    end
                end
                STOP: begin
                    if (clk_fe) begin
                        eval      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            ps2_clk_oe <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            ps2_clk_oe <= inhibit;

            if (state_nxt == IDLE || clk_fe) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (start) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end
            // LSB arrives first, so entering at the top leaves bit 0 at shreg[0].
            if (shift) begin
                shreg   <= {dat_lvl, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (cap_par) begin
                par_bit <= dat_lvl;
            end
            if (tmo_fire) begin
                frame_err <= 1'b1;
                shreg     <= '0;
            end
            if (eval) begin
                if (!dat_lvl) begin
                    frame_err <= 1'b1;
                end else if (odd_parity(shreg) != par_bit) begin
                    parity_err <= 1'b1;
                end else begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_rx.sv
// Randomised frame bench for ps2_host_rx with a frame-level reference model.
module tb_ps2_host_rx;

    localparam int FL  = 4;
    localparam int T   = 300;
    localparam int Q   = 20;
    localparam int LAT = 3 + FL;
    localparam int K_VALID = 0;
    localparam int K_PERR  = 1;
    localparam int K_FERR  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       inhibit = 1'b0;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    // Open-drain clock: the host pulls the shared line low while inhibiting.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat;

    ps2_host_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .inhibit    (inhibit),
        .ps2_clk_oe (ps2_clk_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
        logic       busy;
    } ev_t;

    ev_t        evq[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         last_fall = 0;
    logic [7:0] model_data = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid)   evq.push_back('{K_VALID, rx_data, cyc, busy});
            if (parity_err) evq.push_back('{K_PERR, rx_data, cyc, busy});
            if (frame_err)  evq.push_back('{K_FERR, rx_data, cyc, busy});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int frame_kind(input logic [7:0] d, input logic par, input logic stop);
        int ones;
        if (!stop) return K_FERR;
        ones = $countones(d) + int'(par);
        if (ones % 2 != 1) return K_PERR;
        return K_VALID;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input bit glitch);
        logic [ps2_pkg::FRAME_BITS-1:0] fb;
        fb = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_dat = fb[i];
            repeat (Q) @(negedge clk);
            dev_clk   = 1'b0;
            last_fall = cyc;
            repeat (2 * Q) @(negedge clk);
            dev_clk = 1'b1;
            if (glitch && i == 3) begin
                repeat (10) @(negedge clk);
                dev_clk = 1'b0;
                repeat (FL - 1) @(negedge clk);
                dev_clk = 1'b1;
                repeat (Q - 10 - (FL - 1)) @(negedge clk);
            end else begin
                repeat (Q) @(negedge clk);
            end
        end
        dev_dat = 1'b1;
    endtask

    task automatic expect_ev(input string tag, input int kind, input logic [7:0] d, input int lat);
        ev_t e;
        check_eq({tag, "_count"}, evq.size(), 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            check_eq({tag, "_kind"}, e.kind, kind);
            if (kind == K_VALID) check_eq({tag, "_byte"}, e.data, d);
            check_eq({tag, "_lat"}, e.cyc - last_fall, lat);
            check_eq({tag, "_busy"}, e.busy, 0);
        end
        check_eq({tag, "_rx_data"}, rx_data, model_data);
        evq.delete();
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                             input logic stop, input bit glitch);
        int k;
        k = frame_kind(d, par, stop);
        send_frame(d, par, stop, ps2_pkg::FRAME_BITS, glitch);
        repeat (10) @(negedge clk);
        if (k == K_VALID) model_data = d;
        expect_ev(tag, k, d, LAT);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ($countones(d) % 2 == 0);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int         mode;

        repeat (5) @(negedge clk);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_parity_err", parity_err, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_clk_oe", ps2_clk_oe, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        run_frame("good_1c", 8'h1C, good_par(8'h1C), 1'b1, 1'b0);
        run_frame("perr_f0", 8'hF0, ~good_par(8'hF0), 1'b1, 1'b0);
        run_frame("ferr_5a", 8'h5A, good_par(8'h5A), 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        run_frame("good_5a", 8'h5A, good_par(8'h5A), 1'b1, 1'b0);

        dev_clk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        dev_clk = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("glitch_idle_events", evq.size(), 0);
        check_eq("glitch_idle_busy", busy, 0);
        run_frame("glitch_29", 8'h29, good_par(8'h29), 1'b1, 1'b1);

        send_frame(8'hA5, 1'b0, 1'b1, 5, 1'b0);
        check_eq("tmo_busy_mid", busy, 1);
        repeat (T + LAT + 20) @(negedge clk);
        expect_ev("tmo", K_FERR, 8'h00, LAT + T);
        check_eq("tmo_busy_after", busy, 0);
        run_frame("good_12", 8'h12, good_par(8'h12), 1'b1, 1'b0);

        send_frame(8'h3C, good_par(8'h3C), 1'b1, 4, 1'b0);
        check_eq("inh_busy_mid", busy, 1);
        check_eq("inh_oe_before", ps2_clk_oe, 0);
        inhibit = 1'b1;
        @(negedge clk);
        check_eq("inh_oe", ps2_clk_oe, 1);
        check_eq("inh_busy", busy, 0);
        repeat (100) @(negedge clk);
        check_eq("inh_busy_hold", busy, 0);
        inhibit = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("inh_oe_release", ps2_clk_oe, 0);
        check_eq("inh_events", evq.size(), 0);
        check_eq("inh_rx_data", rx_data, model_data);

        send_frame(8'h81, good_par(8'h81), 1'b1, 6, 1'b0);
        check_eq("mrst_busy_mid", busy, 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        model_data = 8'h00;
        check_eq("mrst_rx_data", rx_data, 8'h00);
        check_eq("mrst_rx_valid", rx_valid, 0);
        check_eq("mrst_parity_err", parity_err, 0);
        check_eq("mrst_frame_err", frame_err, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_clk_oe", ps2_clk_oe, 0);
        rst_n = 1'b1;
        evq.delete();
        repeat (20) @(negedge clk);
        run_frame("good_76", 8'h76, good_par(8'h76), 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            d    = 8'($urandom_range(0, 255));
            mode = int'($urandom_range(0, 3));
            case (mode)
                2:       run_frame("rnd_perr", d, ~good_par(d), 1'b1, 1'b0);
                3:       run_frame("rnd_ferr", d, good_par(d), 1'b0, 1'b0);
                default: run_frame("rnd_good", d, good_par(d), 1'b1, 1'b0);
            endcase
            repeat (int'($urandom_range(5, 40))) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
